// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
// The lock feature is compiled in with macro UART_ARB_LOCK_EN.
package uart_arb_pkg;

  localparam int N_REQ_DEF       = 4;
  localparam int DATA_W_DEF      = 8;
  localparam int ACK_TIMEOUT_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first asserted request at or after i_start, wrapping at N.
// Purely combinational; the caller owns the pointer.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_start,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx
);

  logic [2*N-1:0] w_req2;
  logic [N-1:0]   w_rot;
  logic [IDX_W:0] w_sum;

  // Rotating the doubled vector puts i_start at bit 0, so the lowest set bit wins.
  always_comb begin
    w_req2  = {i_req, i_req};
    w_rot   = N'(w_req2 >> i_start);
    o_valid = 1'b0;
    o_idx   = '0;
    w_sum   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        o_valid = 1'b1;
        w_sum   = {1'b0, i_start} + (IDX_W + 1)'(k);
        if (w_sum >= (IDX_W + 1)'(N)) begin
          w_sum = w_sum - (IDX_W + 1)'(N);
        end
        o_idx = w_sum[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N_REQ byte sources, round-robin, with ack timeout.
// Macro UART_ARB_LOCK_EN lets a requester keep the grant for consecutive bytes.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ       = N_REQ_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_lock,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      uart_wr,
  output logic [DATA_W-1:0]         uart_dat,
  input  logic                      uart_busy,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic                      arb_busy,
  output logic                      err_timeout
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  // Handshake: a requester holds req_valid/req_data until it sees a one-cycle
  // req_ready pulse; the byte was captured when the FSM left IDLE, so the
  // requester may change data or drop valid right after the pulse.

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic [IDX_W-1:0]  r_grant;
  logic [IDX_W-1:0]  w_grant_nxt;
  logic [DATA_W-1:0] r_dat;
  logic [DATA_W-1:0] w_dat_nxt;
  logic [CNT_W-1:0]  r_ack_cnt;
  logic [CNT_W-1:0]  w_ack_cnt_nxt;
  logic              r_err;
  logic              w_err_nxt;

  logic [IDX_W-1:0]  w_rr_start;
  logic              w_pick_valid;
  logic [IDX_W-1:0]  w_pick_idx;
  logic              w_lock_hit;
  logic              w_sel_valid;
  logic [IDX_W-1:0]  w_sel_idx;
  logic [DATA_W-1:0] w_req_byte [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_bytes
    assign w_req_byte[g] = req_data[g*DATA_W +: DATA_W];
  end

  assign w_rr_start = (r_grant == IDX_W'(N_REQ - 1)) ? '0 : r_grant + IDX_W'(1);

  rr_pick #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .i_req   (req_valid),
    .i_start (w_rr_start),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx)
  );

`ifdef UART_ARB_LOCK_EN
  // Armed only by a normally completed byte; reset and timeouts leave it clear.
  logic r_lock_arm;
  logic w_lock_arm_nxt;

  assign w_lock_hit = r_lock_arm && req_lock[r_grant] && req_valid[r_grant];
`else
  logic w_unused_lock;

  assign w_unused_lock = ^req_lock;
  assign w_lock_hit    = 1'b0;
`endif

  assign w_sel_valid = w_lock_hit || w_pick_valid;
  assign w_sel_idx   = w_lock_hit ? r_grant : w_pick_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_grant   <= IDX_W'(N_REQ - 1);
      r_dat     <= '0;
      r_ack_cnt <= '0;
      r_err     <= 1'b0;
`ifdef UART_ARB_LOCK_EN
      r_lock_arm <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_dat     <= w_dat_nxt;
      r_ack_cnt <= w_ack_cnt_nxt;
      r_err     <= w_err_nxt;
`ifdef UART_ARB_LOCK_EN
      r_lock_arm <= w_lock_arm_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_dat_nxt     = r_dat;
    w_ack_cnt_nxt = r_ack_cnt;
    w_err_nxt     = r_err;
`ifdef UART_ARB_LOCK_EN
    w_lock_arm_nxt = r_lock_arm;
`endif
    unique case (r_state)
      ST_IDLE: begin
        if (w_sel_valid) begin
          w_grant_nxt = w_sel_idx;
          w_dat_nxt   = w_req_byte[w_sel_idx];
          w_state_nxt = ST_ISSUE;
`ifdef UART_ARB_LOCK_EN
          w_lock_arm_nxt = 1'b0;
`endif
        end
      end
      ST_ISSUE: begin
        w_ack_cnt_nxt = '0;
        w_state_nxt   = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (uart_busy) begin
          w_state_nxt = ST_WAIT_DONE;
        end else if (r_ack_cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
          // The byte counts as consumed; it is never retried.
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_ack_cnt_nxt = r_ack_cnt + CNT_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!uart_busy) begin
          w_state_nxt = ST_IDLE;
`ifdef UART_ARB_LOCK_EN
          w_lock_arm_nxt = 1'b1;
`endif
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (r_state == ST_ISSUE) begin
      req_ready[r_grant] = 1'b1;
    end
    uart_wr     = (r_state == ST_ISSUE);
    uart_dat    = r_dat;
    grant_id    = r_grant;
    arb_busy    = (r_state != ST_IDLE);
    err_timeout = r_err;
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected (grant, byte) pairs are queued by
// the stimulus, and a monitor pops one on every uart_wr strobe.
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_lock = '0;
  logic [N-1:0]    req_ready;
  logic            uart_wr;
  logic [DW-1:0]   uart_dat;
  logic            uart_busy = 1'b0;
  logic [IW-1:0]   grant_id;
  logic            arb_busy;
  logic            err_timeout;

  int checks = 0;
  int failures = 0;
  logic [IW+DW-1:0] exp_q[$];
  logic [IW+DW-1:0] mon_e;

  int rem[N];
  int lock_left[N];
  int hold_cycles = 10;
  bit never_ack = 1'b0;
  int busy_cnt = 0;
  bit busy_pend = 1'b0;
  int cyc = 0;
  int last_wr_cyc = -100;
  int wr_count = 0;
  int wr_before;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_REQ       (N),
    .DATA_W      (DW),
    .ACK_TIMEOUT (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_lock    (req_lock),
    .req_ready   (req_ready),
    .uart_wr     (uart_wr),
    .uart_dat    (uart_dat),
    .uart_busy   (uart_busy),
    .grant_id    (grant_id),
    .arb_busy    (arb_busy),
    .err_timeout (err_timeout)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int id, input logic [DW-1:0] d);
    exp_q.push_back({IW'(id), d});
  endtask

  task automatic set_req(input int i, input logic [DW-1:0] d, input int n);
    req_data[i*DW +: DW] = d;
    rem[i] = n;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_uart_wr"}, 32'(uart_wr), 0);
    check({tag, "_req_ready"}, 32'(req_ready), 0);
    check({tag, "_uart_dat"}, 32'(uart_dat), 0);
    check({tag, "_grant_id"}, 32'(grant_id), N - 1);
    check({tag, "_arb_busy"}, 32'(arb_busy), 0);
    check({tag, "_err_timeout"}, 32'(err_timeout), 0);
  endtask

  task automatic wait_wr(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!uart_wr && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_wr_seen"}, 32'(uart_wr), 1);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || arb_busy || uart_busy || req_valid != '0) && n < 600) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drained"}, 32'(n < 600), 1);
  endtask

  // Requesters: each holds valid while it has bytes left and consumes one per ready pulse.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (req_ready[i] && rem[i] > 0) begin
        rem[i]--;
        if (lock_left[i] > 0) lock_left[i]--;
      end
      req_valid[i] = (rem[i] > 0);
      req_lock[i]  = (rem[i] > 0) && (lock_left[i] > 0);
    end
  end

  // UART model: busy rises the cycle after a strobe and stays up for hold_cycles.
  always @(negedge clk) begin
    if (rst) begin
      uart_busy = 1'b0;
      busy_cnt  = 0;
      busy_pend = 1'b0;
    end else begin
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) uart_busy = 1'b0;
      end
      if (busy_pend) begin
        uart_busy = 1'b1;
        busy_cnt  = hold_cycles;
        busy_pend = 1'b0;
      end
      if (uart_wr && !never_ack) busy_pend = 1'b1;
    end
  end

  // Monitor: every strobe must match the head of the expected queue.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (uart_wr) begin
        wr_count++;
        check("wr_spacing", 32'((cyc - last_wr_cyc) >= 4), 1);
        last_wr_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_wr: got dat 0x%0h id %0d, expected no strobe", uart_dat, grant_id);
        end else begin
          mon_e = exp_q.pop_front();
          check("uart_dat", 32'(uart_dat), 32'(mon_e[DW-1:0]));
          check("grant_id", 32'(grant_id), 32'(mon_e[IW+DW-1:DW]));
          check("req_ready", 32'(req_ready), 32'(1) << mon_e[IW+DW-1:DW]);
        end
      end else begin
        check("req_ready_quiet", 32'(req_ready), 0);
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      rem[i] = 0;
      lock_left[i] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // Round-robin, every requester valid: 0,1,2,3 then wrap to 0.
    hold_cycles = 3;
    set_req(0, 8'hA0, 2);
    set_req(1, 8'hA1, 2);
    set_req(2, 8'hA2, 2);
    set_req(3, 8'hA3, 2);
    for (int r = 0; r < 2; r++) begin
      push(0, 8'hA0);
      push(1, 8'hA1);
      push(2, 8'hA2);
      push(3, 8'hA3);
    end
    wait_drain("rr");

    // Single requester with a long UART busy period.
    @(posedge clk);
    #1;
    hold_cycles = 10;
    wr_before = wr_count;
    set_req(0, 8'h55, 1);
    push(0, 8'h55);
    wait_wr("single");
    repeat (5) @(negedge clk);
    check("single_uart_busy_mid", 32'(uart_busy), 1);
    check("single_arb_busy_mid", 32'(arb_busy), 1);
    wait_drain("single");
    check("single_wr_count", wr_count - wr_before, 1);

    // Timeout: no ack, four WAIT_ACK cycles, then sticky error and back to IDLE.
    @(posedge clk);
    #1;
    never_ack = 1'b1;
    set_req(2, 8'h7E, 1);
    push(2, 8'h7E);
    wait_wr("timeout");
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check("timeout_err_early", 32'(err_timeout), 0);
      check("timeout_arb_busy", 32'(arb_busy), 1);
    end
    @(negedge clk);
    check("timeout_err_set", 32'(err_timeout), 1);
    check("timeout_idle", 32'(arb_busy), 0);
    @(posedge clk);
    #1;
    never_ack = 1'b0;
    set_req(3, 8'h3C, 1);
    push(3, 8'h3C);
    wait_drain("after_timeout");
    check("err_sticky", 32'(err_timeout), 1);

    // Reset during WAIT_DONE: outputs return to reset values, byte is not re-issued.
    @(posedge clk);
    #1;
    set_req(1, 8'h99, 1);
    push(1, 8'h99);
    wait_wr("midreset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");
    @(posedge clk);
    #1;
    set_req(0, 8'hC0, 1);
    set_req(1, 8'hC1, 1);
    set_req(3, 8'h3C, 1);
    push(0, 8'hC0);
    push(1, 8'hC1);
    push(3, 8'h3C);
    wait_drain("post_reset");

    // Requester 1 asks to keep the grant for its first three bytes.
    @(posedge clk);
    #1;
    hold_cycles = 3;
    lock_left[1] = 3;
    set_req(1, 8'h11, 3);
    set_req(2, 8'h22, 2);
`ifdef UART_ARB_LOCK_EN
    push(1, 8'h11);
    push(1, 8'h11);
    push(1, 8'h11);
    push(2, 8'h22);
    push(2, 8'h22);
`else
    push(1, 8'h11);
    push(2, 8'h22);
    push(1, 8'h11);
    push(2, 8'h22);
    push(1, 8'h11);
`endif
    wait_drain("lock");

    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, the number of requesters (2..8).
REQ-002 SHALL have parameter DATA_W, default 8, the byte width.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 4, the maximum cycles from uart_wr to the rise of uart_busy.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on posedge clk.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port req_valid, input, N_REQ, per-requester byte-pending flag.
REQ-007 SHALL have port req_data, input, N_REQ*DATA_W, per-requester byte; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-008 SHALL have port req_lock, input, N_REQ, a per-requester "keep grant for my next byte" flag.
REQ-009 SHALL have port req_ready, output, N_REQ, a one-cycle accept pulse to the granted requester.
REQ-010 SHALL have port uart_wr, output, 1, the write strobe to the UART transmitter.
REQ-011 SHALL have port uart_dat, output, DATA_W, the byte to the UART transmitter.
REQ-012 SHALL have port uart_busy, input, 1, the UART transmitter busy flag.
REQ-013 SHALL have port grant_id, output, $clog2(N_REQ), the index of the current or last granted requester.
REQ-014 SHALL have port arb_busy, output, 1, high whenever the FSM is not in IDLE.
REQ-015 SHALL have port err_timeout, output, 1, a sticky flag that the UART failed to acknowledge.

Function
REQ-016 SHALL implement the FSM states IDLE, ISSUE, WAIT_ACK and WAIT_DONE.
REQ-017 In IDLE with any req_valid high, the block SHALL pick a winner round-robin, starting at (last_grant+1) mod N_REQ, register grant_id and uart_dat, and go to ISSUE.
REQ-018 In IDLE with no req_valid, the block SHALL remain in IDLE and hold uart_wr at 0.
REQ-019 In ISSUE, the block SHALL assert uart_wr and req_ready[grant_id] for exactly one cycle, then go to WAIT_ACK.
REQ-020 req_data SHALL be sampled only at the IDLE->ISSUE transition; uart_dat SHALL stay stable from ISSUE until the FSM re-enters IDLE.
REQ-021 In WAIT_ACK, the block SHALL go to WAIT_DONE on uart_busy=1.
REQ-022 If uart_busy is still 0 after ACK_TIMEOUT cycles in WAIT_ACK, the block SHALL set err_timeout, go to IDLE, and record the byte as consumed (no retry).
REQ-023 In WAIT_DONE, the block SHALL go to IDLE on uart_busy=0.
REQ-024 Minimum spacing between uart_wr pulses SHALL be 4 cycles; there is no back-to-back strobe.
REQ-025 A requester dropping req_valid after its grant SHALL NOT abort the byte already issued.
REQ-026 At most one req_ready bit SHALL be high in any cycle.
REQ-027 The round-robin pointer SHALL wrap from N_REQ-1 to 0.
REQ-028 An empty arbitration cycle SHALL NOT advance the pointer.

Reset
REQ-029 On rst=1 at a clock edge, the block SHALL enter IDLE with uart_wr=0, req_ready=0, uart_dat=0, grant_id=N_REQ-1 (so requester 0 wins first), arb_busy=0 and err_timeout=0.
REQ-030 Reset SHALL abort any in-flight state immediately; the interrupted byte SHALL NOT be re-issued.
REQ-031 err_timeout SHALL clear only on reset.

Configuration
REQ-032 With macro UART_ARB_LOCK_EN defined, the block SHALL re-grant the previous requester if, on returning to IDLE, req_lock[grant_id] and req_valid[grant_id] are both 1, regardless of the round-robin order.
REQ-033 With macro UART_ARB_LOCK_EN defined, a timeout SHALL break the lock.
REQ-034 Without UART_ARB_LOCK_EN, the block SHALL ignore req_lock and use pure round-robin.

Structure
REQ-035 Package uart_arb_pkg SHALL hold the FSM state enum and the default constants N_REQ_DEF=4, DATA_W_DEF=8 and ACK_TIMEOUT_DEF=4.
REQ-036 Round-robin selection SHALL be a sub-module rr_pick, a combinational function of (req vector, pointer) giving (valid, index).
REQ-037 The FSM, timeout counter and lock logic SHALL reside in uart_tx_arbiter.

Verification
REQ-038 Single requester: req_valid=4'b0001, data 0x55; UART model raises busy 1 cycle after wr and holds it 10 cycles -> exactly one uart_wr with uart_dat=0x55, one req_ready[0] pulse, arb_busy high until busy falls.
REQ-039 Round-robin: all four valid continuously with data 0xA0..0xA3 -> uart_dat order 0xA0,0xA1,0xA2,0xA3,0xA0, grant_id wrapping 3->0.
REQ-040 Timeout: UART model never raises busy, one request 0x7E -> uart_wr once, err_timeout=1 after 4 WAIT_ACK cycles, FSM back in IDLE, the next request still served.
REQ-041 Reset mid-transfer: assert rst during WAIT_DONE -> next cycle all outputs at reset values, err_timeout=0, then requester 0 wins first.
REQ-042 Lock (UART_ARB_LOCK_EN): req 1 and req 2 valid, req_lock[1]=1 for 3 bytes -> grants 1,1,1,2; with the macro undefined -> grants 1,2,1,2.
